fan_ctrl_multi: RTL and testbench

Parametrised multi-channel fan controller: drives NUM_FANS 25 kHz PWM fan outputs from one shared period counter, applies per-channel slew-limited duty ramping, and measures each fan's tachometer to report RPM pulse counts and stall flags. Duty commands arrive through the existing FWFT-FIFO read interface (valid/data in, read-enable out) from the PS register path. It replaces the single-channel fan block in the top level.

---
 rtl/fan_ctrl_multi.sv | 176 +++++++++++++++++
 tb/tb_fan_ctrl_multi.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fan_ctrl_multi.sv
// fan_ctrl_multi: NUM_FANS inverted PWM fan outputs sharing one period counter,
// slew-limited duty ramping toward per-channel targets loaded from an FWFT
// command stream, and per-channel tach edge counting with stall detection.
module fan_ctrl_multi #(
    parameter int NUM_FANS      = 4,
    parameter int CLK_HZ        = 100000000,
    parameter int PWM_HZ        = 25000,
    parameter int MIN_PCT       = 10,
    parameter int RAMP_STEP     = 8,
    parameter int TACH_WINDOW   = 25000,
    parameter int STALL_WINDOWS = 2
) (
    input  logic                    clk100,
    input  logic                    rst_n,
    input  logic                    fan_ctrl_valid,
    input  logic [31:0]             fan_ctrl_read_rd_data,
    output logic                    fan_ctrl_read_rd_en,
    output logic                    cmd_err,
    input  logic [NUM_FANS-1:0]     fan_tach,
    output logic [NUM_FANS-1:0]     fan_pwm,
    output logic [16*NUM_FANS-1:0]  tach_count,
    output logic                    tach_valid,
    output logic [NUM_FANS-1:0]     stall
);

    localparam int PERIOD   = CLK_HZ / PWM_HZ;
    localparam int CW       = $clog2(PERIOD) + 1;
    localparam int MIN_DUTY = PERIOD * MIN_PCT / 100;
    localparam int MAX_DUTY = PERIOD - 1;
    localparam int WW       = $clog2(TACH_WINDOW + 1);
    localparam int ZW       = $clog2(STALL_WINDOWS + 1);

    localparam logic [CW-1:0] DUTY_MIN = CW'(MIN_DUTY);
    localparam logic [CW-1:0] DUTY_MAX = CW'(MAX_DUTY);
    localparam logic [CW-1:0] STEP     = CW'(RAMP_STEP);
    localparam logic [WW-1:0] WIN_LAST = WW'(TACH_WINDOW - 1);
    localparam logic [ZW-1:0] ZERO_SAT = ZW'(STALL_WINDOWS);

    logic [CW-1:0]       pwm_count;
    logic [WW-1:0]       win_cnt;
    logic                period_end;
    logic                win_end;
    logic [CW-1:0]       target   [NUM_FANS];
    logic [CW-1:0]       cur      [NUM_FANS];
    logic [CW-1:0]       cur_next [NUM_FANS];
    logic [NUM_FANS-1:0] pwm_reg;

    logic [7:0]          cmd_ch;
    logic [CW-1:0]       cmd_duty;
    logic [CW-1:0]       cmd_clamped;
    logic                ch_ok;
    logic                accept;
    logic                unused_bits;

    logic [NUM_FANS-1:0] tach_s0;
    logic [NUM_FANS-1:0] tach_s1;
    logic [NUM_FANS-1:0] tach_s2;
    logic [NUM_FANS-1:0] tach_edge;
    logic [15:0]         edge_cnt  [NUM_FANS];
    logic [ZW-1:0]       zero_cnt  [NUM_FANS];
    logic [ZW-1:0]       zero_next [NUM_FANS];

    assign period_end  = (pwm_count == DUTY_MAX);
    assign win_end     = period_end && (win_cnt == WIN_LAST);
    assign fan_pwm     = ~pwm_reg;
    assign tach_edge   = tach_s1 & ~tach_s2;

    assign cmd_ch      = fan_ctrl_read_rd_data[31:24];
    assign cmd_duty    = fan_ctrl_read_rd_data[CW-1:0];
    assign unused_bits = ^fan_ctrl_read_rd_data[23:CW];
    assign ch_ok       = ({1'b0, cmd_ch} < 9'(NUM_FANS));
    // Holding rd_en for the cycle after a pop keeps a still-presented FWFT word from being taken twice.
    assign accept      = fan_ctrl_valid && !fan_ctrl_read_rd_en;
    assign cmd_clamped = (cmd_duty < DUTY_MIN) ? DUTY_MIN :
                         (cmd_duty > DUTY_MAX) ? DUTY_MAX : cmd_duty;

    // Next ramped duty per channel: step toward target, landing exactly on it when close.
    always_comb begin
        for (int i = 0; i < NUM_FANS; i++) begin
            cur_next[i] = cur[i];
            if (target[i] > cur[i]) begin
                cur_next[i] = ((target[i] - cur[i]) > STEP) ? cur[i] + STEP : target[i];
            end else if (target[i] < cur[i]) begin
                cur_next[i] = ((cur[i] - target[i]) > STEP) ? cur[i] - STEP : target[i];
            end
        end
    end

    // Consecutive zero-count windows, saturating at the stall threshold.
    always_comb begin
        for (int i = 0; i < NUM_FANS; i++) begin
            zero_next[i] = '0;
            if (edge_cnt[i] == 16'd0) begin
                zero_next[i] = (zero_cnt[i] >= ZERO_SAT) ? ZERO_SAT : zero_cnt[i] + 1'b1;
            end
        end
    end

    // Shared PWM period counter and count of completed periods in the tach window.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            pwm_count <= '0;
            win_cnt   <= '0;
        end else begin
            pwm_count <= period_end ? '0 : pwm_count + 1'b1;
            if (period_end) begin
                win_cnt <= win_end ? '0 : win_cnt + 1'b1;
            end
        end
    end

    // Per-channel target/current duty and registered PWM compare; reset is full speed.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FANS; i++) begin
                target[i] <= DUTY_MAX;
                cur[i]    <= DUTY_MAX;
            end
            pwm_reg <= '1;
        end else begin
            for (int i = 0; i < NUM_FANS; i++) begin
                pwm_reg[i] <= (pwm_count <= cur[i]);
                if (period_end) begin
                    cur[i] <= cur_next[i];
                end
                if (accept && ch_ok && (cmd_ch == 8'(i))) begin
                    target[i] <= cmd_clamped;
                end
            end
        end
    end

    // Command pop and bad-channel error pulses.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            fan_ctrl_read_rd_en <= 1'b0;
            cmd_err             <= 1'b0;
        end else begin
            fan_ctrl_read_rd_en <= accept;
            cmd_err             <= accept && !ch_ok;
        end
    end

    // Tach synchroniser, edge counting, window latch and stall tracking.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            tach_s0    <= '0;
            tach_s1    <= '0;
            tach_s2    <= '0;
            tach_valid <= 1'b0;
            tach_count <= '0;
            stall      <= '0;
            for (int i = 0; i < NUM_FANS; i++) begin
                edge_cnt[i] <= '0;
                zero_cnt[i] <= '0;
            end
        end else begin
            tach_s0    <= fan_tach;
            tach_s1    <= tach_s0;
            tach_s2    <= tach_s1;
            tach_valid <= win_end;
            for (int i = 0; i < NUM_FANS; i++) begin
                if (win_end) begin
                    tach_count[16*i +: 16] <= edge_cnt[i];
                    // An edge on the latch cycle belongs to the next window.
                    edge_cnt[i] <= {15'd0, tach_edge[i]};
                    zero_cnt[i] <= zero_next[i];
                    stall[i]    <= (zero_next[i] >= ZERO_SAT);
                end else if (tach_edge[i] && (edge_cnt[i] != 16'hFFFF)) begin
                    edge_cnt[i] <= edge_cnt[i] + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fan_ctrl_multi.sv
// Self-checking bench for fan_ctrl_multi: reduced PWM period so ramps and tach
// windows fit a short run; a cycle-level reference model predicts every output.
module tb_fan_ctrl_multi;

    localparam int NF     = 4;
    localparam int CLK_HZ = 100_000_000;
    localparam int PWM_HZ = 1_000_000;
    localparam int P      = CLK_HZ / PWM_HZ;
    localparam int CW     = $clog2(P) + 1;
    localparam int DMIN   = P * 10 / 100;
    localparam int DMAX   = P - 1;
    localparam int STEP   = 8;
    localparam int TW     = 4;
    localparam int SW     = 2;
    localparam int W      = P * TW;

    logic              clk100 = 1'b0;
    logic              rst_n  = 1'b1;
    logic              fan_ctrl_valid = 1'b0;
    logic [31:0]       fan_ctrl_read_rd_data = '0;
    logic              fan_ctrl_read_rd_en;
    logic              cmd_err;
    logic [NF-1:0]     fan_tach = '0;
    logic [NF-1:0]     fan_pwm;
    logic [16*NF-1:0]  tach_count;
    logic              tach_valid;
    logic [NF-1:0]     stall;

    fan_ctrl_multi #(
        .NUM_FANS(NF), .CLK_HZ(CLK_HZ), .PWM_HZ(PWM_HZ), .MIN_PCT(10),
        .RAMP_STEP(STEP), .TACH_WINDOW(TW), .STALL_WINDOWS(SW)
    ) dut (
        .clk100(clk100),
        .rst_n(rst_n),
        .fan_ctrl_valid(fan_ctrl_valid),
        .fan_ctrl_read_rd_data(fan_ctrl_read_rd_data),
        .fan_ctrl_read_rd_en(fan_ctrl_read_rd_en),
        .cmd_err(cmd_err),
        .fan_tach(fan_tach),
        .fan_pwm(fan_pwm),
        .tach_count(tach_count),
        .tach_valid(tach_valid),
        .stall(stall)
    );

    always #5 clk100 = ~clk100;

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          m_tgt [NF];
    int          m_cur [NF];
    int          m_cnt [NF];
    int          m_zc  [NF];
    int          plan  [NF];
    int          exp_win [NF];
    bit          m_rd, m_err, m_tv;
    bit          bnd, prev_bnd, force_bnd, rand_cmd;
    int          hold_left;
    logic [31:0] cmd_word;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int clamp_duty(input int d);
        if (d < DMIN) return DMIN;
        if (d > DMAX) return DMAX;
        return d;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [7:0] ch;
        ch = ($urandom_range(0, 5) == 5) ? 8'($urandom) : 8'($urandom_range(0, 4));
        return {ch, 16'($urandom), 8'($urandom_range(0, 255))};
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < NF; i++) begin
            m_tgt[i] = DMAX;
            m_cur[i] = DMAX;
            m_cnt[i] = 0;
            m_zc[i]  = 0;
            plan[i]  = 0;
            exp_win[i] = 0;
        end
        m_rd = 0; m_err = 0; m_tv = 0;
        bnd = 0; prev_bnd = 0; hold_left = 0;
    endtask

    task automatic send_cmd(input int ch, input int d, input int hold);
        cmd_word  = {8'(ch), 16'($urandom), 8'(d)};
        hold_left = hold;
    endtask

    // One clock: drive inputs, advance the model across the edge, compare all outputs.
    task automatic tick();
        int o, k, ch, d;
        bit acc, hi;
        logic [NF-1:0]    e_pwm, e_stall;
        logic [16*NF-1:0] e_tc;

        if (hold_left == 0 && rand_cmd && $urandom_range(0, 25) == 0) begin
            cmd_word  = rand_word();
            hold_left = $urandom_range(1, 4);
        end
        if (hold_left > 0) begin
            fan_ctrl_valid = 1'b1;
            fan_ctrl_read_rd_data = cmd_word;
            hold_left--;
        end else begin
            fan_ctrl_valid = 1'b0;
            fan_ctrl_read_rd_data = $urandom();
        end

        o = cyc % W;
        if (o == 0) begin
            prev_bnd = bnd;
            plan[0] = $urandom_range(1, 50);
            plan[1] = $urandom_range(0, 50);
            plan[2] = 0;
            plan[3] = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 50);
            for (int i = 0; i < NF; i++) exp_win[i] = plan[i] + ((i == 1 && prev_bnd) ? 1 : 0);
            bnd = force_bnd || ($urandom_range(0, 2) == 0);
            force_bnd = 0;
        end
        for (int i = 0; i < NF; i++) begin
            hi = (o >= 20) && (o < 20 + 6 * plan[i]) && (((o - 20) % 6) < 3);
            if (i == 1 && bnd && o >= W - 3) hi = 1;
            if (i == 1 && prev_bnd && o < 3) hi = 1;
            fan_tach[i] = hi;
        end

        @(posedge clk100);
        cyc++;
        k = (cyc - 1) % P;
        for (int i = 0; i < NF; i++) e_pwm[i] = !(k <= m_cur[i]);
        if (k == P - 1) begin
            for (int i = 0; i < NF; i++) begin
                d = m_tgt[i] - m_cur[i];
                if (d > STEP)       m_cur[i] += STEP;
                else if (d < -STEP) m_cur[i] -= STEP;
                else                m_cur[i] = m_tgt[i];
            end
        end
        acc   = fan_ctrl_valid && !m_rd;
        ch    = int'(fan_ctrl_read_rd_data[31:24]);
        d     = int'(fan_ctrl_read_rd_data[CW-1:0]);
        m_rd  = acc;
        m_err = acc && (ch >= NF);
        if (acc && ch < NF) m_tgt[ch] = clamp_duty(d);
        m_tv = (cyc % W == 0);
        if (m_tv) begin
            for (int i = 0; i < NF; i++) begin
                m_cnt[i] = exp_win[i];
                m_zc[i]  = (m_cnt[i] == 0) ? ((m_zc[i] + 1 > SW) ? SW : m_zc[i] + 1) : 0;
            end
        end
        for (int i = 0; i < NF; i++) begin
            e_stall[i] = (m_zc[i] >= SW);
            e_tc[16*i +: 16] = 16'(m_cnt[i]);
        end

        #1;
        check_eq("fan_pwm", 64'(fan_pwm), 64'(e_pwm));
        check_eq("rd_en", 64'(fan_ctrl_read_rd_en), 64'(m_rd));
        check_eq("cmd_err", 64'(cmd_err), 64'(m_err));
        check_eq("tach_valid", 64'(tach_valid), 64'(m_tv));
        check_eq("tach_count", 64'(tach_count), 64'(e_tc));
        check_eq("stall", 64'(stall), 64'(e_stall));
    endtask

    task automatic count_low(input int ch, output int lows);
        lows = 0;
        repeat (P) begin
            tick();
            if (fan_pwm[ch] == 1'b0) lows++;
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        fan_ctrl_valid = 1'b0;
        fan_tach = '0;
        #1;
        check_eq({tag, "_pwm"}, 64'(fan_pwm), 64'd0);
        check_eq({tag, "_stall"}, 64'(stall), 64'd0);
        check_eq({tag, "_tv"}, 64'(tach_valid), 64'd0);
        check_eq({tag, "_rd"}, 64'(fan_ctrl_read_rd_en), 64'd0);
        check_eq({tag, "_err"}, 64'(cmd_err), 64'd0);
        check_eq({tag, "_tc"}, 64'(tach_count), 64'd0);
        repeat (3) @(posedge clk100);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int pops, lows;
        rand_cmd = 0;
        force_bnd = 0;
        cmd_word = '0;
        model_reset();
        #2;
        apply_reset("por");
        repeat (150) tick();

        send_cmd(1, 50, 4);
        tick();
        check_eq("rd_latency", 64'(fan_ctrl_read_rd_en), 64'd1);
        pops = int'(fan_ctrl_read_rd_en);
        repeat (5) begin
            tick();
            pops += int'(fan_ctrl_read_rd_en);
        end
        check_eq("pops_held4", 64'(pops), 64'd2);
        repeat (12 * P) tick();
        count_low(1, lows);
        check_eq("low_ch1_d50", 64'(lows), 64'(50 + 1));
        count_low(0, lows);
        check_eq("low_ch0_untouched", 64'(lows), 64'(P));
        check_eq("stall2_set", 64'(stall[2]), 64'd1);
        check_eq("stall0_clear", 64'(stall[0]), 64'd0);

        send_cmd(1, 0, 1);
        repeat (10 * P) tick();
        count_low(1, lows);
        check_eq("low_ch1_clamp_min", 64'(lows), 64'(DMIN + 1));

        send_cmd(1, 255, 1);
        repeat (13 * P) tick();
        count_low(1, lows);
        check_eq("low_ch1_clamp_max", 64'(lows), 64'(P));

        send_cmd(4, 30, 1);
        tick();
        check_eq("bad_ch_err", 64'(cmd_err), 64'd1);
        check_eq("bad_ch_rd", 64'(fan_ctrl_read_rd_en), 64'd1);
        tick();
        check_eq("bad_ch_err_pulse", 64'(cmd_err), 64'd0);

        send_cmd(0, 0, 1);
        repeat (3 * P) tick();
        send_cmd(0, 95, 1);
        repeat (8 * P) tick();
        count_low(0, lows);
        check_eq("low_ch0_retarget", 64'(lows), 64'(95 + 1));

        rand_cmd = 1;
        force_bnd = 1;
        repeat (20 * W) tick();

        rand_cmd = 0;
        while (hold_left > 0) tick();
        send_cmd(3, 0, 1);
        repeat (3 * P + 95) tick();
        check_eq("stall2_before_rst", 64'(stall[2]), 64'd1);
        #1;
        apply_reset("midrun");

        send_cmd(2, 20, 1);
        rand_cmd = 1;
        force_bnd = 1;
        repeat (6 * W) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
